// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Debounces a bank of bouncing board switches. Each bit is synchronised by two
// flops and then runs its own STABLE/COUNTING FSM. A new level is accepted only
// after DEBOUNCE_CYCLES consecutive cycles of disagreement with the current
// debounced level. Accepted changes produce one-cycle rise/fall pulses and set
// a sticky pending flag that feeds a level interrupt.
//
// Ports:
//   S_AXI_ACLK     in   1   clock, all state updates on its rising edge
//   S_AXI_ARESETN  in   1   asynchronous active-low reset
//   sw_raw         in   W   raw asynchronous switch pins
//   switches       out  W   registered debounced levels
//   sw_rise        out  W   one-cycle pulse on each accepted 0->1 change
//   sw_fall        out  W   one-cycle pulse on each accepted 1->0 change
//   sw_pending     out  W   sticky per-bit change flags
//   irq_clear      in   W   write-1-to-clear strobe for sw_pending
//   irq_enable     in   1   interrupt enable
//   irq            out  1   irq_enable & |sw_pending
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int SWITCH_WIDTH    = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [SWITCH_WIDTH-1:0] sw_raw,
  output logic [SWITCH_WIDTH-1:0] switches,
  output logic [SWITCH_WIDTH-1:0] sw_rise,
  output logic [SWITCH_WIDTH-1:0] sw_fall,
  output logic [SWITCH_WIDTH-1:0] sw_pending,
  input  logic [SWITCH_WIDTH-1:0] irq_clear,
  input  logic                    irq_enable,
  output logic                    irq
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

  // Counter value on which the next persistent mismatch is accepted.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [SWITCH_WIDTH-1:0] sync1_q;
  logic [SWITCH_WIDTH-1:0] sync2_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < SWITCH_WIDTH; gi++) begin : g_bit
    db_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;
    logic                 pend_q, pend_d;
    logic                 accept;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      accept  = 1'b0;

      unique case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (sync2_q[gi] != level_q) begin
            state_d = ST_COUNTING;
            cnt_d   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_COUNTING: begin
          if (sync2_q[gi] == level_q) begin
            // Bounce back before the count completed: drop it silently.
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            level_d = sync2_q[gi];
            rise_d  = sync2_q[gi];
            fall_d  = ~sync2_q[gi];
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            // cnt_q < CNT_LAST <= max, so this cannot wrap.
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      endcase

      // A new change wins over a simultaneous clear strobe.
      pend_d = accept | (pend_q & ~irq_clear[gi]);
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        pend_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        pend_q  <= pend_d;
      end
    end

    assign switches[gi]   = level_q;
    assign sw_rise[gi]    = rise_q;
    assign sw_fall[gi]    = fall_q;
    assign sw_pending[gi] = pend_q;
  end

  // Only registered terms feed irq, so raw pin activity cannot glitch it.
  assign irq = irq_enable & (|sw_pending);

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;
  localparam int W = 8;
  localparam int D = 4;

  logic         clk        = 1'b0;
  logic         aresetn    = 1'b1;
  logic [W-1:0] sw_raw     = '0;
  logic [W-1:0] irq_clear  = '0;
  logic         irq_enable = 1'b0;
  logic [W-1:0] switches, sw_rise, sw_fall, sw_pending;
  logic         irq;

  switch_debounce #(
    .SWITCH_WIDTH   (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_WIDTH      (20)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(aresetn),
    .sw_raw       (sw_raw),
    .switches     (switches),
    .sw_rise      (sw_rise),
    .sw_fall      (sw_fall),
    .sw_pending   (sw_pending),
    .irq_clear    (irq_clear),
    .irq_enable   (irq_enable),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  typedef struct packed {
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] pend;
    logic         irq;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a level is accepted when the last D synchronised samples
  // (raw samples from two edges earlier and before) all disagree with it.
  logic [W-1:0] m_level;
  logic [W-1:0] m_pend;
  logic [W-1:0] m_win[$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s cycle=%0d got=%02h want=%02h", name, cycle, got, want);
    end
  endtask

  function automatic void model_reset();
    m_level = '0;
    m_pend  = '0;
    m_win.delete();
    for (int j = 0; j <= D; j++) m_win.push_back('0);
  endfunction

  // Model: steps once per rising edge, pushes the expected post-edge outputs.
  initial begin
    logic [W-1:0] acc;
    exp_t         e;
    model_reset();
    forever begin
      @(posedge clk or negedge aresetn);
      if (!aresetn) begin
        model_reset();
      end else begin
        acc = '1;
        for (int j = 0; j < D; j++) acc &= (m_win[j] ^ m_level);
        m_level = m_level ^ acc;
        m_pend  = (m_pend & ~irq_clear) | acc;
        e.sw    = m_level;
        e.rise  = acc & m_level;
        e.fall  = acc & ~m_level;
        e.pend  = m_pend;
        e.irq   = irq_enable & (|m_pend);
        exp_q.push_back(e);
        void'(m_win.pop_front());
        m_win.push_back(sw_raw);
      end
    end
  end

  // Monitor: compares DUT outputs 1 time unit after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("switches", switches, e.sw);
        check("sw_rise", sw_rise, e.rise);
        check("sw_fall", sw_fall, e.fall);
        check("sw_pending", sw_pending, e.pend);
        check("irq", W'(irq), W'(e.irq));
        $display("cyc=%0d raw=%02h sw=%02h rise=%02h fall=%02h pend=%02h irq=%0b",
                 cycle, sw_raw, switches, sw_rise, sw_fall, sw_pending, irq);
      end
    end
  end

  task automatic drive(input logic [W-1:0] raw, input logic [W-1:0] clr,
                       input logic en, input int n);
    repeat (n) begin
      @(negedge clk);
      sw_raw     = raw;
      irq_clear  = clr;
      irq_enable = en;
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_switches"}, switches, '0);
    check({tag, "_rise"}, sw_rise, '0);
    check({tag, "_fall"}, sw_fall, '0);
    check({tag, "_pending"}, sw_pending, '0);
    check({tag, "_irq"}, W'(irq), '0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    check_reset_zero("rst_async");
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    logic [W-1:0] raw;
    logic [W-1:0] clr;
    logic         en;

    #2 aresetn = 1'b0;
    #1 check_reset_zero("rst_init");
    repeat (3) @(negedge clk);
    aresetn = 1'b1;

    // Clean step and release.
    drive(8'h01, 8'h00, 1'b1, 9);
    drive(8'h00, 8'h00, 1'b1, 9);
    // Clear pending.
    drive(8'h00, 8'h01, 1'b1, 1);
    drive(8'h00, 8'h00, 1'b1, 2);
    // Three-cycle glitch.
    drive(8'h01, 8'h00, 1'b1, 3);
    drive(8'h00, 8'h00, 1'b1, 8);
    // Clear landing on the acceptance edge: set must win.
    drive(8'h01, 8'h00, 1'b1, 5);
    drive(8'h01, 8'h01, 1'b1, 1);
    drive(8'h01, 8'h00, 1'b1, 3);
    drive(8'h01, 8'hFF, 1'b1, 1);
    drive(8'h00, 8'h00, 1'b1, 9);
    drive(8'h00, 8'hFF, 1'b1, 1);
    // Two bits together, bit 7 bounces once mid-count.
    drive(8'h81, 8'h00, 1'b1, 2);
    drive(8'h01, 8'h00, 1'b1, 1);
    drive(8'h81, 8'h00, 1'b1, 10);
    drive(8'h00, 8'h00, 1'b1, 9);
    drive(8'h00, 8'hFF, 1'b0, 1);
    // irq_enable gating with pending set, then raise enable mid-cycle.
    drive(8'h02, 8'h00, 1'b0, 9);
    @(negedge clk);
    irq_enable = 1'b1;
    #1;
    check("irq_en_pend_nonzero", W'(|m_pend), W'(1));
    check("irq_en_comb", W'(irq), W'(irq_enable & (|m_pend)));
    drive(8'h02, 8'h00, 1'b1, 2);
    drive(8'h00, 8'hFF, 1'b1, 9);
    drive(8'h00, 8'hFF, 1'b1, 1);
    // Reset at counter=2 with all bits high, then recovery.
    drive(8'hFF, 8'h00, 1'b1, 4);
    reset_pulse();
    drive(8'hFF, 8'h00, 1'b1, 10);
    drive(8'hFF, 8'hFF, 1'b1, 1);

    // Randomised traffic with occasional resets.
    raw = 8'hFF;
    for (int i = 0; i < 3000; i++) begin
      raw = raw ^ W'($urandom & $urandom & $urandom & $urandom);
      clr = W'($urandom & $urandom & $urandom);
      en  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) reset_pulse();
      drive(raw, clr, en, 1);
    end

    drive(raw, 8'h00, 1'b1, 3);
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound the run in case stimulus ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout cycle=%0d got=running want=finished", cycle);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/switch_debounce.md
SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 SHALL have parameter SWITCH_WIDTH, default 8, the number of switch inputs; each bit is debounced independently.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), the number of consecutive mismatch cycles needed to accept a new level; legal range 2..2^CNT_WIDTH-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 20, the width of each per-bit counter.
REQ-004 S_AXI_ACLK  in  1  sole clock; all state is updated on its rising edge.
REQ-005 S_AXI_ARESETN  in  1  asynchronous, active-low reset.
REQ-006 sw_raw  in  SWITCH_WIDTH  asynchronous, bouncing board switch pins.
REQ-007 switches  out  SWITCH_WIDTH  registered debounced levels; connect to the switches input of the GPIO slave.
REQ-008 sw_rise  out  SWITCH_WIDTH  one-cycle pulse per bit on each accepted 0->1 change.
REQ-009 sw_fall  out  SWITCH_WIDTH  one-cycle pulse per bit on each accepted 1->0 change.
REQ-010 sw_pending  out  SWITCH_WIDTH  sticky per-bit change flags.
REQ-011 irq_clear  in  SWITCH_WIDTH  write-1-to-clear strobe for sw_pending, sampled each cycle.
REQ-012 irq_enable  in  1  interrupt enable.
REQ-013 irq  out  1  level interrupt.

Function
REQ-014 Each sw_raw bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-015 Each bit SHALL run a 2-state FSM: STABLE (sync2 == switches) and COUNTING (sync2 != switches).
REQ-016 In STABLE, the bit's counter SHALL be 0; the first cycle sync2 differs, the FSM SHALL move to COUNTING with the counter set to 1.
REQ-017 In COUNTING, if sync2 returns to equal switches, the FSM SHALL return to STABLE with the counter cleared to 0, and switches, the edge outputs and sw_pending SHALL be unchanged (glitch rejection).
REQ-018 In COUNTING, if the mismatch persists and the counter equals DEBOUNCE_CYCLES-1, the next edge SHALL load switches[i] <= sync2[i], clear the counter and return to STABLE; otherwise the counter SHALL increment by 1 and never wrap.
REQ-019 Latency: a clean raw change SHALL appear on switches at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new level as 1.
REQ-020 sw_rise[i]/sw_fall[i] SHALL be registered, high for exactly the one cycle in which switches[i] first shows the new value, and never both high.
REQ-021 sw_pending[i] SHALL be set on the edge at which switches[i] changes and cleared by irq_clear[i]=1; when set and clear occur in the same cycle, set SHALL win.
REQ-022 irq SHALL equal irq_enable AND (OR-reduce of sw_pending), combinational from registers and free of glitches from sw_raw.
REQ-023 Bits SHALL be fully independent; simultaneous changes on several bits SHALL each debounce, pulse and flag on their own schedule.
REQ-024 A raw level that toggles faster than DEBOUNCE_CYCLES SHALL never change switches.

Reset
REQ-025 On S_AXI_ARESETN=0, immediately and without a clock: sync1, sync2, switches, all counters, sw_rise, sw_fall and sw_pending SHALL be 0, all FSMs SHALL be STABLE, and irq SHALL be 0.
REQ-026 Reset asserted during COUNTING SHALL discard the partial count; after release, counting SHALL restart from 0.
REQ-027 A switch held at 1 through reset SHALL debounce to 1 after release, producing a normal sw_rise pulse and sw_pending set.

Verification (DEBOUNCE_CYCLES=4, SWITCH_WIDTH=8)
REQ-028 Clean step: sw_raw 0x00->0x01 sampled at edge 1 -> switches=0x01 and sw_rise=0x01 at edge 6 only; sw_pending=0x01; irq=1 when irq_enable=1.
REQ-029 Glitch: sw_raw[0] high for 3 cycles, then low -> switches remains 0x00; no sw_rise/sw_fall; sw_pending=0x00.
REQ-030 Release and clear: from 0x01, sw_raw->0x00 -> sw_fall=0x01 pulse at edge 6; irq_clear=0x01 -> sw_pending=0x00 and irq=0 next cycle; an irq_clear coinciding with a new change leaves the bit set.
REQ-031 Multi-bit: sw_raw 0x00->0x81 together, then bit 7 bounces once mid-count -> bit 0 accepted at edge 6, bit 7 at the later time determined by its restarted count; per-bit pulses are independent.
REQ-032 Reset mid-count: assert S_AXI_ARESETN=0 at counter=2 with sw_raw=0xFF held -> outputs 0 immediately; after release, switches=0xFF with sw_rise=0xFF exactly 6 edges later.
REQ-033 irq_enable=0 with sw_pending non-zero -> irq=0; raising irq_enable -> irq=1 in the same cycle.
